// File: rtl/cpu_timer_pkg.sv
// Shared types and constants for the cpu_timer block and its prescaler.
package cpu_timer_pkg;

    localparam int TIMER_W          = 16;
    localparam int DEFAULT_PRESCALE = 50000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    // Prescaler counter width: enough bits for 0..prescale-1, never below one bit.
    function automatic int presc_w(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/cpu_timer_if.sv
// ALU <-> timer link: start strobe toward the timer, count and status back.
interface cpu_timer_if #(
    parameter int WIDTH = cpu_timer_pkg::TIMER_W
);

    logic             start;
    logic [WIDTH-1:0] timer;
    logic             running;
    logic             ovf;

    modport master (output start, input timer, running, ovf);
    modport slave  (input start, output timer, running, ovf);

endinterface

// File: rtl/cpu_timer_prescaler.sv
// Clock divider: counts 0..PRESCALE-1 while enabled and pulses tick on the terminal value.
module timer_prescaler
    import cpu_timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W = presc_w(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_timer.sv
// Elapsed-time tick counter serving the ALU START/GET opcodes.
// Define CPU_TIMER_SATURATE_EN to freeze at all ones (HALT) instead of wrapping to zero.
module cpu_timer
    import cpu_timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int WIDTH    = TIMER_W
) (
    input logic        clk,
    input logic        rst_n,
    cpu_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] TIMER_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] timer_q;
    logic [WIDTH-1:0] timer_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             start_q;
    logic             start_evt;
    logic             tick;

    // A held strobe is one event: only the rising edge restarts the count.
    assign start_evt = bus.start & ~start_q;

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_evt | (state_q != RUN)),
        .en   (state_q == RUN),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        ovf_d   = ovf_q;
        if (start_evt) begin
            // Restart wins over a coincident tick.
            state_d = RUN;
            timer_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN && tick) begin
            if (timer_q == TIMER_MAX) begin
                ovf_d = 1'b1;
`ifdef CPU_TIMER_SATURATE_EN
                state_d = HALT;
`else
                timer_d = '0;
`endif
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
            start_q <= bus.start;
        end
    end

    assign bus.timer   = timer_q;
    assign bus.running = (state_q == RUN);
    assign bus.ovf     = ovf_q;

endmodule

// File: doc/cpu_timer.md
# cpu_timer

Free-running elapsed-time counter that sits beside the ALU and serves its timer instructions. Consumes the ALU's combinational `start` strobe (START opcode) and supplies the registered 16-bit `timer` value read by the GET opcode. Counts prescaled clock ticks from the most recent start event, so software can measure intervals in fixed tick units.

## Interface
- `PRESCALE`, 50000, clock cycles per tick (≥1); 1 ms at 50 MHz.
- `WIDTH`, 16, tick counter width; must equal the ALU data width.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  combinational start strobe from ALU decode; may be high several cycles.
- `timer`  out  WIDTH  registered tick count to the ALU GET path.
- `running`  out  1  high while counting.
- `ovf`  out  1  sticky: count passed its maximum since the last start.

## Operation
- Start detection: `start` registered into `start_q`; start event = `start & ~start_q` (rising edge). A held `start` is exactly one event.
- States: IDLE, RUN, HALT.
  - IDLE (reset state): `timer` holds 0, prescaler held at 0; start event → RUN.
  - RUN: prescaler counts 0..PRESCALE-1; on terminal value it wraps to 0 and `timer` increments by 1.
  - Count at max (all ones) with a tick due: see Configuration; HALT is reached only with saturation enabled.
  - HALT: `timer` frozen at all ones, `ovf`=1; start event → RUN.
- Any start event in any state: `timer`←0, prescaler←0, `ovf`←0, state←RUN, all in the same edge. Restart in RUN takes priority over a coincident tick (tick is discarded).
- `running` = (state == RUN).
- Arithmetic unsigned, modulo 2^WIDTH; prescaler width = $clog2(PRESCALE), minimum 1 bit. PRESCALE=1 → tick every RUN cycle.

## Timing
- Reset (async assert, sync release edge irrelevant): `timer`=0, `running`=0, `ovf`=0, `start_q`=0, state IDLE, prescaler 0. Reset mid-count discards all progress.
- Start edge seen on cycle N → on edge N+1: `timer`=0, `running`=1.
- First increment: `timer`=1 after PRESCALE cycles in RUN, i.e. at edge N+1+PRESCALE; subsequent increments every PRESCALE cycles.
- `start` low for one cycle then high again → second event, counter restarts.
- `timer` changes only on clock edges; GET in the ALU sees a stable value all cycle.

## Configuration
- `CPU_TIMER_SATURATE_EN` defined: on a tick with `timer` all ones, `timer` stays all ones, `ovf`←1, state→HALT.
- Undefined: on that tick `timer` wraps to 0, `ovf`←1 (sticky until start/reset), state stays RUN; HALT state unreachable and may be omitted.

## Structure
- Package `cpu_timer_pkg`: state enum (IDLE, RUN, HALT), `TIMER_W`=16 constant, default prescale constant.
- Sub-module `timer_prescaler`: parameter PRESCALE; inputs `clk`, `rst_n`, `clr`, `en`; output one-cycle `tick` on terminal count. Top holds edge detect, FSM, tick counter, flags.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN with `timer`=5 → `timer`=0, `running`=0, `ovf`=0 immediately, without a clock edge.
- PRESCALE=4: single-cycle `start` at cycle 10 → `running`=1 at 11, `timer`=1 at 15, 2 at 19, 3 at 23.
- PRESCALE=4: `start` held high 20 cycles → one event only; `timer` reaches 5 at cycle 31, no restarts.
- PRESCALE=4, RUN with `timer`=7: new start pulse on the cycle a tick is due → next edge `timer`=0, not 8.
- PRESCALE=1, WIDTH=16, with saturation: count from start → `timer`=0xFFFF after 65535 ticks, one tick later `ovf`=1, `running`=0, `timer` stays 0xFFFF; start → `timer`=0, `ovf`=0.
- Same without saturation → `timer` wraps to 0x0000, `ovf`=1, `running`=1, next tick `timer`=1 with `ovf` still 1.
